genie_merge_fifo: RTL and testbench
===================================

# genie_merge_fifo

Packet-aware synchronous FIFO placed directly downstream of a merge node. It absorbs the merged valid/ready/eop/data stream and decouples the merge output from backpressure on the downstream link. The FIFO stores payload and end-of-packet together, and reports its fill level. An optional compile-time store-and-forward mode holds a packet until all of it is buffered.

## Interface
- WIDTH, default 1: payload width in bits. WIDTH=0 is legal; only eop is then stored.
- DEPTH, default 4: number of entries. Must be a power of two and at least 2; other values are a compile-time error.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- i_data  in  WIDTH  payload from the merge node.
- i_valid  in  1  input word is present.
- o_ready  out  1  FIFO accepts a word this cycle.
- i_eop  in  1  input word is the last word of its packet.
- o_valid  out  1  output word is present.
- o_data  out  WIDTH  payload at the FIFO head.
- i_ready  in  1  downstream accepts the word.
- o_eop  out  1  the head word is the last word of its packet.
- o_level  out  $clog2(DEPTH+1)  number of entries currently stored.

## Operation
- Storage is a DEPTH-entry array of {eop, data}, with a write pointer, a read pointer and an occupancy counter.
- Each pointer is $clog2(DEPTH) bits and wraps naturally from DEPTH-1 to 0.
- Push occurs when i_valid && o_ready. Entry[wptr] is written and wptr is incremented.
- Pop occurs when o_valid && i_ready. rptr is incremented.
- o_ready = (o_level != DEPTH). It depends only on registered state, so there is no combinational path from i_valid or i_ready.
- o_valid = (o_level != 0), subject to the Configuration section.
- o_data and o_eop present entry[rptr] (first-word fall-through from the array).
- When o_valid is low, o_data and o_eop are don't-care.
- Level update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on a simultaneous push and pop.
- Full: o_ready is low and no push occurs. A pop in the same cycle does not enable a push; the freed slot becomes visible next cycle.
- Empty: o_valid is low. A push in the same cycle does not bypass to the output.
- Protocol violations are ignored and do not corrupt state:
  - i_valid while o_ready is low: no push.
  - i_ready while o_valid is low: no pop.
- Reset values:
  - Pointers, level and packet counter = 0.
  - o_valid = 0, o_level = 0, o_ready = 1 (only after reset has released, during the same cycle reset is low).
  - While reset is high, o_ready = 0.
  - Array contents are not reset.
- Reset mid-packet discards all stored words, including partial packets. Upstream is responsible for re-framing.

## Timing
- Latency from a push in cycle N to the word appearing on o_valid is cycle N+1 when the FIFO was empty.
- Throughput is one word per cycle in steady state with i_ready held high.
- After a pop from a full FIFO in cycle N, o_ready rises in cycle N+1.
- A simultaneous push and pop at level L ≥ 1 leaves the level at L.
- The wrap-around of wptr/rptr from DEPTH-1 to 0 introduces no bubble.
- o_level is registered and reflects all pushes and pops completed before the current cycle.

## Configuration
- Macro: GENIE_MERGE_FIFO_SF_EN.
- Defined (store-and-forward mode):
  - A packet counter, $clog2(DEPTH+1) bits, counts the complete packets stored.
  - It increments on a push with eop and decrements on a pop with eop. On a simultaneous push-eop and pop-eop it is unchanged.
  - o_valid = (o_level != 0) && (pkt_count != 0 || o_level == DEPTH).
  - The full override prevents deadlock on packets longer than DEPTH; such packets degrade to cut-through.
- Undefined (cut-through mode):
  - No packet counter is built.
  - o_valid = (o_level != 0).

## Test plan
- Reset, then idle: o_ready=1, o_valid=0, o_level=0. Then push 0x5 with eop=1 and i_ready=0: next cycle o_valid=1, o_data=0x5, o_eop=1, o_level=1.
- DEPTH=4, i_ready=0, push 0x1..0x4: o_level=4 and o_ready=0. A fifth i_valid is not accepted. Then set i_ready=1: pops return 0x1,0x2,0x3,0x4 in order, and o_ready rises the cycle after the first pop.
- Continuous stream of 16 words with i_valid=i_ready=1 at DEPTH=4: output order matches input, one word per cycle, and o_level stays at 1 across all pointer wraps.
- Reset asserted with level=3 mid-packet: next cycle o_level=0 and o_valid=0. After reset deasserts, a new push 0xA is the first word popped.
- With GENIE_MERGE_FIFO_SF_EN defined:
  - Push a 3-word packet (eop on the third word) with i_ready=1: o_valid stays low until the cycle after the eop push, then words 1–3 pop back-to-back.
  - A 6-word packet at DEPTH=4: o_valid rises when level reaches 4, and all 6 words pass through.
- Random valid/ready toggling (≥50% density) with random eop over 10k words in both macro settings: a scoreboard matches data and eop exactly, and o_level never exceeds DEPTH or underflows.

Source files
------------

// File: rtl/genie_merge_fifo.sv
// genie_merge_fifo: packet-aware synchronous FIFO placed after a merge node.
// Stores {eop, data} per entry, first-word fall-through output, registered
// fill level. Optional store-and-forward mode selected by the macro
// GENIE_MERGE_FIFO_SF_EN (undefined: cut-through).
module genie_merge_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_eop,
  output logic                         o_valid,
  output logic [WIDTH-1:0]             o_data,
  input  logic                         i_ready,
  output logic                         o_eop,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  // DEPTH must be a power of two and at least 2
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_depth_check
    $error("genie_merge_fifo: DEPTH must be a power of two >= 2");
  end

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [DEPTH-1:0] eop_mem_q;
  logic             push;
  logic             pop;
  logic             head_eop;

  // Handshakes and status flags; o_ready is held low while reset is asserted
  always_comb begin
    o_ready  = !reset && (level_q != FULL_LVL);
    push     = i_valid && o_ready;
    pop      = o_valid && i_ready;
    head_eop = eop_mem_q[rptr_q];
    o_eop    = head_eop;
    o_level  = level_q;
  end

`ifdef GENIE_MERGE_FIFO_SF_EN
  logic [LW-1:0] pkt_q, pkt_d;

  // Complete-packet count; a full FIFO releases data anyway so long packets cannot deadlock
  always_comb begin
    pkt_d = pkt_q;
    case ({push && i_eop, pop && head_eop})
      2'b10:   pkt_d = pkt_q + LW'(1);
      2'b01:   pkt_d = pkt_q - LW'(1);
      default: pkt_d = pkt_q;
    endcase
    o_valid = (level_q != '0) && ((pkt_q != '0) || (level_q == FULL_LVL));
  end

  // Packet counter register
  always_ff @(posedge clk) begin
    if (reset) pkt_q <= '0;
    else       pkt_q <= pkt_d;
  end
`else
  // Cut-through: any stored word is presented
  always_comb begin
    o_valid = (level_q != '0);
  end
`endif

  // Next pointer and level values
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // End-of-packet storage (not reset)
  always_ff @(posedge clk) begin
    if (push) eop_mem_q[wptr_q] <= i_eop;
  end

  if (WIDTH > 0) begin : gen_data
    logic [WIDTH-1:0] data_mem_q [DEPTH];

    // Payload storage (not reset)
    always_ff @(posedge clk) begin
      if (push) data_mem_q[wptr_q] <= i_data;
    end

    // First-word fall-through read of the head entry
    always_comb begin
      o_data = data_mem_q[rptr_q];
    end
  end else begin : gen_no_data
    logic unused_data;

    // No payload is stored; only eop travels through the FIFO
    always_comb begin
      unused_data = ^i_data;
      o_data      = '0;
    end
  end

endmodule

// File: tb/tb_genie_merge_fifo.sv
// Scoreboard bench for genie_merge_fifo (WIDTH=8, DEPTH=4), valid for both
// settings of GENIE_MERGE_FIFO_SF_EN.
module tb_genie_merge_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             i_eop;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             i_ready;
  logic             o_eop;
  logic [LW-1:0]    o_level;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the FIFO as a plain queue of {eop,data}
  logic [WIDTH:0] mq [$];
  // Scoreboard of words expected on the output, in order
  logic [WIDTH:0] sb [$];

  genie_merge_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_eop   (i_eop),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready),
    .o_eop   (o_eop),
    .o_level (o_level)
  );

  always #5 clk = ~clk;

  function automatic logic model_ready();
    return mq.size() != DEPTH;
  endfunction

  // Output is offered when something is stored; store-and-forward additionally
  // needs a complete packet inside, or a full FIFO.
  function automatic logic model_valid();
    int n = 0;
    if (mq.size() == 0) return 1'b0;
`ifdef GENIE_MERGE_FIFO_SF_EN
    foreach (mq[i]) if (mq[i][WIDTH]) n++;
    return (n != 0) || (mq.size() == DEPTH);
`else
    n = 1;
    return n != 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on the clock edge, driven only by stimulus and model state
  always @(posedge clk) begin
    logic mv, mr;
    if (reset) begin
      mq.delete();
      sb.delete();
    end else begin
      mv = model_valid();
      mr = model_ready();
      if (mv && i_ready) void'(mq.pop_front());
      if (i_valid && mr) begin
        mq.push_back({i_eop, i_data});
        sb.push_back({i_eop, i_data});
      end
    end
  end

  // Monitor: status flags every cycle; pops the scoreboard on each DUT handshake
  always @(negedge clk) begin
    logic [WIDTH:0] e;
    if (reset) begin
      chk("ready_in_reset", int'(o_ready), 0);
    end else begin
      chk("o_ready", int'(o_ready), int'(model_ready()));
      chk("o_valid", int'(o_valid), int'(model_valid()));
      chk("o_level", int'(o_level), mq.size());
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("o_data", int'(o_data), int'(e[WIDTH-1:0]));
          chk("o_eop", int'(o_eop), int'(e[WIDTH]));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic e, input logic r);
    i_valid = v;
    i_data  = d;
    i_eop   = e;
    i_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_eop   = 1'b0;
    i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 8'h00, 0, 0);

    // Single word with eop, held by downstream, then popped
    step(1, 8'h05, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);

    // Fill to full, one rejected extra word, then drain in order
    for (int k = 1; k <= 4; k++) step(1, WIDTH'(k), (k == 4), 0);
    step(1, 8'hEE, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 8'h00, 0, 1);

    // Continuous stream across pointer wraps
    for (int k = 0; k < 16; k++) step(1, 8'h10 + WIDTH'(k), (k % 4 == 3), 1);
    for (int k = 0; k < 6; k++) step(0, 8'h00, 0, 1);

    // Reset in the middle of a partial packet
    for (int k = 0; k < 3; k++) step(1, 8'h20 + WIDTH'(k), 0, 0);
    reset = 1'b1;
    step(0, 8'h00, 0, 0);
    reset = 1'b0;
    step(0, 8'h00, 0, 0);
    step(1, 8'h0A, 1, 0);
    for (int k = 0; k < 3; k++) step(0, 8'h00, 0, 1);

    // 3-word packet, then 6-word packet longer than DEPTH
    for (int k = 0; k < 3; k++) step(1, 8'h30 + WIDTH'(k), (k == 2), 1);
    for (int k = 0; k < 4; k++) step(0, 8'h00, 0, 1);
    for (int k = 0; k < 6; k++) step(1, 8'h40 + WIDTH'(k), (k == 5), 1);
    for (int k = 0; k < 8; k++) step(0, 8'h00, 0, 1);

    // Random valid/ready/eop traffic
    for (int k = 0; k < 20000; k++)
      step(($urandom_range(3) != 0), WIDTH'($urandom), ($urandom_range(3) == 0),
           ($urandom_range(3) != 0));
    // Terminate any open packet and drain
    step(1, 8'hFF, 1, 1);
    for (int k = 0; k < 4 * DEPTH + 8; k++) step(0, 8'h00, 0, 1);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
